sram_stream_checker: RTL and testbench
======================================

Name: sram_stream_checker

Overview:
- Synthesizable result checker for the accelerator's banked output SRAM.
- Walks a flat word index across NUM_BANKS banks of BANK_DEPTH words each, reading one word per cycle.
- Compares the low DATA_W bits of each word, as a signed value, against a golden byte stream with a configurable ±TOL tolerance.
- Counts passes and errors. Sits beside the output SRAM, muxed in after the engine raises finish, and replaces per-word hierarchical peeking.

Parameters:
NUM_BANKS, 6, number of SRAM banks in the output array
BANK_DEPTH, 32768, words per bank (power of two)
WORD_W, 16, SRAM word width
DATA_W, 8, compared field width (word bits [DATA_W-1:0], signed)
TOL, 1, allowed absolute difference (0 = exact match)
CNT_W, 32, width of count and index outputs

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
start_i  in  1  one-cycle pulse that begins a check
num_words_i  in  CNT_W  words to check; sampled on start_i
gold_valid_i  in  1  golden stream valid
gold_data_i  in  DATA_W  golden value, signed
gold_ready_o  out  1  golden accepted when valid&ready
sram_cs_o  out  NUM_BANKS  one-hot bank read enable
sram_addr_o  out  $clog2(BANK_DEPTH)  in-bank word address
sram_rdata_i  in  NUM_BANKS*WORD_W  concatenated bank read data; bank b at [b*WORD_W +: WORD_W]
busy_o  out  1  check in progress
finish_o  out  1  one-cycle done pulse
pass_cnt_o  out  CNT_W  words within tolerance
err_cnt_o  out  CNT_W  words outside tolerance

Behaviour:
- One clock (clk); reset is synchronous and active-low (rstn). All state updates on posedge clk.
- Reset values: gold_ready_o=0, sram_cs_o=0, sram_addr_o=0, busy_o=0, finish_o=0, pass_cnt_o=0, err_cnt_o=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start_i, latch total = min(num_words_i, NUM_BANKS*BANK_DEPTH).
  - Clear both counters, bank=0, addr=0, and go to RUN.
  - If total==0, go directly to DONE instead.
- RUN:
  - gold_ready_o = 1 while the issued count is below total. The count includes the word in the cycle now being accepted.
  - On a golden accept: sram_cs_o[bank]=1 that cycle with sram_addr_o=addr, and the golden value is registered.
  - Address walk: addr increments; at BANK_DEPTH-1 it wraps to 0 and bank increments. No divider is used.
  - No accept means sram_cs_o=0 and the walk does not advance, so bubbles are allowed.
  - After the last accept, go to DRAIN.
- SRAM read latency is fixed at 1 cycle. The compare uses sram_rdata_i of the bank selected in the previous cycle (bank index is pipelined).
- Compare:
  - out = rdata[DATA_W-1:0] signed.
  - diff = out - gold, computed in DATA_W+2 bits with no wrap, so 127 vs -128 is an error.
  - |diff| <= TOL increments pass_cnt_o; otherwise err_cnt_o increments.
  - Counters saturate at all-ones.
- DRAIN: wait one cycle for the final compare, then go to DONE.
- DONE: finish_o=1 for exactly one cycle, busy_o drops, return to IDLE. Counters hold until the next start_i.
- busy_o=1 in RUN and DRAIN.
- start_i while busy_o=1 is ignored.
- Reset asserted mid-check aborts at once: all outputs return to reset values and no finish_o pulse is issued.
- Any num_words_i above capacity is clamped to NUM_BANKS*BANK_DEPTH words.

Optional Feature:
CHECKER_FIRST_ERR_EN
- Defined: adds outputs first_err_vld_o (1), first_err_idx_o (CNT_W), first_err_out_o (DATA_W) and first_err_gold_o (DATA_W).
  - Captured on the first error after start_i and held until the next start_i.
  - Cleared to 0 on reset and on start_i.
  - The index is the flat word number.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- NUM_BANKS=2, BANK_DEPTH=8, banks preloaded with flat index 0..15 = value i, golden = i, num_words=16, gold_valid held high -> sram_cs_o sequence 01×8 then 10×8, addresses 0..7 twice, finish_o pulses exactly 3 cycles after last accept handshake cycle+1, pass=16, err=0.
- Same memory; golden[3]=i+1, golden[5]=i-1, golden[7]=i+2 with TOL=1 -> pass=15, err=1; with FIRST_ERR_EN, first_err_idx_o=7, out=7, gold=9.
- Word = 0x007F, golden=-128 (0x80) -> error counted, proving no wrap-around.
- gold_valid_i toggling 1,0,0,1 over 10 words -> no SRAM access in bubble cycles, addresses contiguous, final pass=10.
- num_words=0 -> finish_o pulse 2 cycles after start_i, counts 0, no sram_cs_o activity; num_words=100 with 16-word capacity -> exactly 16 accepts.
- rstn low for one cycle after 5 accepts -> all outputs reset, no finish_o; a second start_i afterwards runs cleanly with fresh counts.

Source files
------------

// File: rtl/sram_stream_checker.sv
// Checks banked output SRAM against a golden stream: 1-cycle SRAM read, compare the cycle after, golden held off by gold_ready_o.
// Define CHECKER_FIRST_ERR_EN to add first-error capture (index, observed and golden value).
module sram_stream_checker #(
  parameter int NUM_BANKS  = 6,
  parameter int BANK_DEPTH = 32768,
  parameter int WORD_W     = 16,
  parameter int DATA_W     = 8,
  parameter int TOL        = 1,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start_i,
  input  logic [CNT_W-1:0]              num_words_i,
  input  logic                          gold_valid_i,
  input  logic [DATA_W-1:0]             gold_data_i,
  output logic                          gold_ready_o,
  output logic [NUM_BANKS-1:0]          sram_cs_o,
  output logic [$clog2(BANK_DEPTH)-1:0] sram_addr_o,
  input  logic [NUM_BANKS*WORD_W-1:0]   sram_rdata_i,
  output logic                          busy_o,
  output logic                          finish_o,
  output logic [CNT_W-1:0]              pass_cnt_o,
  output logic [CNT_W-1:0]              err_cnt_o
`ifdef CHECKER_FIRST_ERR_EN
  ,
  output logic                          first_err_vld_o,
  output logic [CNT_W-1:0]              first_err_idx_o,
  output logic [DATA_W-1:0]             first_err_out_o,
  output logic [DATA_W-1:0]             first_err_gold_o
`endif
);

  localparam int ADDR_W = $clog2(BANK_DEPTH);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int DIFF_W = DATA_W + 2;
  localparam logic [CNT_W-1:0]  CAPACITY  = CNT_W'(NUM_BANKS * BANK_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BANK_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_total;
  logic [CNT_W-1:0]    r_issued;
  logic [BANK_W-1:0]   r_bank;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_ready;
  logic                r_busy;
  logic                r_finish;
  logic [CNT_W-1:0]    r_pass;
  logic [CNT_W-1:0]    r_err;
  logic                r_rd_vld;
  logic [BANK_W-1:0]   r_rd_bank;
  logic [DATA_W-1:0]   r_gold;
`ifdef CHECKER_FIRST_ERR_EN
  logic [CNT_W-1:0]    r_rd_idx;
  logic                r_fe_vld;
  logic [CNT_W-1:0]    r_fe_idx;
  logic [DATA_W-1:0]   r_fe_out;
  logic [DATA_W-1:0]   r_fe_gold;
`endif

  logic                w_accept;
  logic [CNT_W-1:0]    w_issued_nxt;
  logic [CNT_W-1:0]    w_total;
  logic [NUM_BANKS-1:0] w_cs;
  logic [31:0]         w_rd_lsb;
  logic [DATA_W-1:0]   w_out;
  logic [DIFF_W-1:0]   w_diff;
  logic [DIFF_W-1:0]   w_abs;
  logic                w_in_tol;

  assign w_accept     = gold_valid_i & r_ready;
  assign w_issued_nxt = r_issued + CNT_W'(1);
  assign w_total      = (num_words_i > CAPACITY) ? CAPACITY : num_words_i;

  always_comb begin
    w_cs = '0;
    if (w_accept) w_cs[r_bank] = 1'b1;
  end

  // Read data belongs to the bank selected one cycle earlier.
  assign w_rd_lsb = 32'(r_rd_bank) * 32'(WORD_W);
  assign w_out    = sram_rdata_i[w_rd_lsb +: DATA_W];

  // Two guard bits keep the signed difference exact (127 - (-128) = 255).
  assign w_diff   = {{2{w_out[DATA_W-1]}}, w_out} - {{2{r_gold[DATA_W-1]}}, r_gold};
  assign w_abs    = w_diff[DIFF_W-1] ? (~w_diff + DIFF_W'(1)) : w_diff;
  assign w_in_tol = (w_abs <= DIFF_W'(TOL));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_total   <= '0;
      r_issued  <= '0;
      r_bank    <= '0;
      r_addr    <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_finish  <= 1'b0;
      r_pass    <= '0;
      r_err     <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_bank <= '0;
      r_gold    <= '0;
`ifdef CHECKER_FIRST_ERR_EN
      r_rd_idx  <= '0;
      r_fe_vld  <= 1'b0;
      r_fe_idx  <= '0;
      r_fe_out  <= '0;
      r_fe_gold <= '0;
`endif
    end else begin
      r_finish <= 1'b0;
      r_rd_vld <= w_accept;
      if (w_accept) begin
        r_rd_bank <= r_bank;
        r_gold    <= gold_data_i;
`ifdef CHECKER_FIRST_ERR_EN
        r_rd_idx  <= r_issued;
`endif
      end

      if (r_rd_vld) begin
        if (w_in_tol) begin
          if (r_pass != CNT_MAX) r_pass <= r_pass + CNT_W'(1);
        end else begin
          if (r_err != CNT_MAX) r_err <= r_err + CNT_W'(1);
`ifdef CHECKER_FIRST_ERR_EN
          if (!r_fe_vld) begin
            r_fe_vld  <= 1'b1;
            r_fe_idx  <= r_rd_idx;
            r_fe_out  <= w_out;
            r_fe_gold <= r_gold;
          end
`endif
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_total  <= w_total;
            r_issued <= '0;
            r_bank   <= '0;
            r_addr   <= '0;
            r_pass   <= '0;
            r_err    <= '0;
`ifdef CHECKER_FIRST_ERR_EN
            r_fe_vld  <= 1'b0;
            r_fe_idx  <= '0;
            r_fe_out  <= '0;
            r_fe_gold <= '0;
`endif
            if (w_total == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_ready <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_issued <= w_issued_nxt;
            if (r_addr == ADDR_LAST) begin
              r_addr <= '0;
              r_bank <= r_bank + BANK_W'(1);
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_issued_nxt >= r_total) begin
              r_ready <= 1'b0;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_finish <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gold_ready_o = r_ready;
  assign sram_cs_o    = w_cs;
  assign sram_addr_o  = r_addr;
  assign busy_o       = r_busy;
  assign finish_o     = r_finish;
  assign pass_cnt_o   = r_pass;
  assign err_cnt_o    = r_err;
`ifdef CHECKER_FIRST_ERR_EN
  assign first_err_vld_o  = r_fe_vld;
  assign first_err_idx_o  = r_fe_idx;
  assign first_err_out_o  = r_fe_out;
  assign first_err_gold_o = r_fe_gold;
`endif

endmodule

// File: tb/tb_sram_stream_checker.sv
// Bench for sram_stream_checker on a 2x8 bank array with a per-cycle handshake/address model and finish-time count model.
module tb_sram_stream_checker;
  localparam int NB  = 2;
  localparam int BD  = 8;
  localparam int WW  = 16;
  localparam int DW  = 8;
  localparam int TOLV = 1;
  localparam int CW  = 32;
  localparam int CAP = NB * BD;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start_i = 1'b0;
  logic [CW-1:0]   num_words_i = '0;
  logic            gold_valid_i = 1'b0;
  logic [DW-1:0]   gold_data_i = '0;
  logic            gold_ready_o;
  logic [NB-1:0]   sram_cs_o;
  logic [2:0]      sram_addr_o;
  logic [NB*WW-1:0] sram_rdata_i = '0;
  logic            busy_o;
  logic            finish_o;
  logic [CW-1:0]   pass_cnt_o;
  logic [CW-1:0]   err_cnt_o;
`ifdef CHECKER_FIRST_ERR_EN
  logic            first_err_vld_o;
  logic [CW-1:0]   first_err_idx_o;
  logic [DW-1:0]   first_err_out_o;
  logic [DW-1:0]   first_err_gold_o;
`endif

  sram_stream_checker #(
    .NUM_BANKS(NB), .BANK_DEPTH(BD), .WORD_W(WW), .DATA_W(DW), .TOL(TOLV), .CNT_W(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .num_words_i(num_words_i),
    .gold_valid_i(gold_valid_i), .gold_data_i(gold_data_i), .gold_ready_o(gold_ready_o),
    .sram_cs_o(sram_cs_o), .sram_addr_o(sram_addr_o), .sram_rdata_i(sram_rdata_i),
    .busy_o(busy_o), .finish_o(finish_o), .pass_cnt_o(pass_cnt_o), .err_cnt_o(err_cnt_o)
`ifdef CHECKER_FIRST_ERR_EN
    ,
    .first_err_vld_o(first_err_vld_o), .first_err_idx_o(first_err_idx_o),
    .first_err_out_o(first_err_out_o), .first_err_gold_o(first_err_gold_o)
`endif
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mem [CAP];
  logic [DW-1:0] gold_arr [128];

  // Synchronous-read SRAM; unselected banks return a poison pattern.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      sram_rdata_i[b*WW +: WW] <= sram_cs_o[b] ? mem[b*BD + int'(sram_addr_o)] : 16'h5A5A;
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int mk = 0;
  int exp_total = 0;
  int exp_pass = 0;
  int exp_err = 0;
  int fin_cnt = 0;
  int fin_cyc = 0;
  int last_hs = 0;
  int start_cyc = 0;
  bit model_on = 1'b0;
  int vpat [4];
  int cs_log [CAP];
  int addr_log [CAP];
`ifdef CHECKER_FIRST_ERR_EN
  bit        fe_vld = 1'b0;
  int        fe_idx = 0;
  logic [DW-1:0] fe_out = '0;
  logic [DW-1:0] fe_gold = '0;
`endif

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic begin_model(input int nw);
    mk = 0;
    exp_pass = 0;
    exp_err = 0;
    exp_total = (nw > CAP) ? CAP : nw;
`ifdef CHECKER_FIRST_ERR_EN
    fe_vld = 1'b0;
    fe_idx = 0;
    fe_out = '0;
    fe_gold = '0;
`endif
  endtask

  // One clock: sample at negedge, compare against the model, return 1 time unit after posedge.
  task automatic tick();
    bit hs;
    int d;
    logic signed [DW-1:0] so;
    logic signed [DW-1:0] sg;
    @(negedge clk);
    cyc++;
    hs = gold_valid_i && gold_ready_o;
    if (model_on) begin
      check("ready", gold_ready_o, (mk < exp_total) ? 1 : 0);
      check("cs", sram_cs_o, hs ? (1 << (mk / BD)) : 0);
      if (hs) check("addr", sram_addr_o, mk % BD);
    end
    if (hs) begin
      so = mem[mk % CAP][DW-1:0];
      sg = gold_data_i;
      d = int'(so) - int'(sg);
      if (d <= TOLV && d >= -TOLV) exp_pass++;
      else begin
        exp_err++;
`ifdef CHECKER_FIRST_ERR_EN
        if (!fe_vld) begin
          fe_vld = 1'b1;
          fe_idx = mk;
          fe_out = so;
          fe_gold = sg;
        end
`endif
      end
      cs_log[mk % CAP] = int'(sram_cs_o);
      addr_log[mk % CAP] = int'(sram_addr_o);
      last_hs = cyc;
      mk++;
    end
    if (finish_o) begin
      fin_cnt++;
      fin_cyc = cyc;
      check("fin_pass", pass_cnt_o, exp_pass);
      check("fin_err", err_cnt_o, exp_err);
`ifdef CHECKER_FIRST_ERR_EN
      check("fin_fe_vld", first_err_vld_o, fe_vld);
      check("fin_fe_idx", first_err_idx_o, fe_idx);
      check("fin_fe_out", first_err_out_o, fe_out);
      check("fin_fe_gold", first_err_gold_o, fe_gold);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int nw, input int plen);
    int fc0;
    int c;
    begin_model(nw);
    gold_valid_i = 1'b0;
    start_i = 1'b1;
    num_words_i = CW'(nw);
    tick();
    start_cyc = cyc;
    start_i = 1'b0;
    check("busy_after_start", busy_o, (exp_total > 0) ? 1 : 0);
    model_on = 1'b1;
    fc0 = fin_cnt;
    c = 0;
    while (fin_cnt == fc0 && c < 300) begin
      gold_valid_i = (vpat[c % plen] != 0);
      gold_data_i = gold_arr[mk % 128];
      tick();
      c++;
    end
    gold_valid_i = 1'b0;
    model_on = 1'b0;
    if (fin_cnt == fc0) check("finish_timeout", 0, 1);
    if (exp_total > 0) check("fin_latency", fin_cyc - last_hs, 3);
    else check("fin_latency_zero", fin_cyc - start_cyc, 2);
    check("fin_one_cycle", finish_o, 0);
    check("busy_after_done", busy_o, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, gold_ready_o, 0);
    check({tag, "_cs"}, sram_cs_o, 0);
    check({tag, "_addr"}, sram_addr_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_finish"}, finish_o, 0);
    check({tag, "_pass"}, pass_cnt_o, 0);
    check({tag, "_err"}, err_cnt_o, 0);
  endtask

  initial begin
    int fc0;
    int c;
    for (int i = 0; i < CAP; i++) mem[i] = 16'(i);
    for (int i = 0; i < 128; i++) gold_arr[i] = 8'(i);
    for (int i = 0; i < 4; i++) vpat[i] = 1;

    tick();
    tick();
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick();

    // Full sweep, exact golden values.
    run(16, 1);
    check("t1_pass", pass_cnt_o, 16);
    check("t1_err", err_cnt_o, 0);
    check("t1_cs0", cs_log[0], 1);
    check("t1_cs8", cs_log[8], 2);
    check("t1_addr7", addr_log[7], 7);
    check("t1_addr8", addr_log[8], 0);
    check("t1_addr15", addr_log[15], 7);

    // Off-by-one goldens pass, off-by-two fails.
    gold_arr[3] = 8'd4;
    gold_arr[5] = 8'd4;
    gold_arr[7] = 8'd9;
    run(16, 1);
    check("t2_pass", pass_cnt_o, 15);
    check("t2_err", err_cnt_o, 1);
`ifdef CHECKER_FIRST_ERR_EN
    check("t2_fe_vld", first_err_vld_o, 1);
    check("t2_fe_idx", first_err_idx_o, 7);
    check("t2_fe_out", first_err_out_o, 7);
    check("t2_fe_gold", first_err_gold_o, 9);
`endif
    for (int i = 0; i < 128; i++) gold_arr[i] = 8'(i);

    // Signed extremes, upper word bits ignored, negative within tolerance.
    mem[0] = 16'h007F; gold_arr[0] = 8'h80;
    mem[1] = 16'h1203; gold_arr[1] = 8'h03;
    mem[2] = 16'h00FE; gold_arr[2] = 8'hFF;
    run(3, 1);
    check("t3_pass", pass_cnt_o, 2);
    check("t3_err", err_cnt_o, 1);
    for (int i = 0; i < 3; i++) begin
      mem[i] = 16'(i);
      gold_arr[i] = 8'(i);
    end

    // Bubbles in the golden stream.
    vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1;
    run(10, 4);
    check("t4_accepts", mk, 10);
    check("t4_pass", pass_cnt_o, 10);
    check("t4_err", err_cnt_o, 0);
    for (int i = 0; i < 4; i++) vpat[i] = 1;

    // Zero-length check, then request beyond capacity.
    run(0, 1);
    check("t5_accepts0", mk, 0);
    check("t5_pass0", pass_cnt_o, 0);
    check("t5_err0", err_cnt_o, 0);
    run(100, 1);
    check("t5_accepts_clamp", mk, 16);
    check("t5_pass_clamp", pass_cnt_o, 16);

    // Abort by reset after five accepts.
    begin_model(16);
    start_i = 1'b1;
    num_words_i = CW'(16);
    tick();
    start_i = 1'b0;
    model_on = 1'b1;
    c = 0;
    while (mk < 5 && c < 50) begin
      gold_valid_i = 1'b1;
      gold_data_i = gold_arr[mk % 128];
      tick();
      c++;
    end
    check("t6_accepts", mk, 5);
    gold_valid_i = 1'b0;
    model_on = 1'b0;
    fc0 = fin_cnt;
    rstn = 1'b0;
    tick();
    check_reset_outputs("t6_abort");
`ifdef CHECKER_FIRST_ERR_EN
    check("t6_fe_vld", first_err_vld_o, 0);
`endif
    rstn = 1'b1;
    repeat (8) tick();
    check("t6_no_finish", fin_cnt, fc0);
    run(16, 1);
    check("t6_rerun_pass", pass_cnt_o, 16);
    check("t6_rerun_err", err_cnt_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
